// File: rtl/upcounter_ctrl.sv
// upcounter_ctrl: start/stop/pause controlled up-counter with one-shot and
// periodic modes. Terminal count and mode are captured when a run starts.
module upcounter_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_limit_q;
    logic [WIDTH-1:0] w_limit_nxt;
    logic             r_mode_q;
    logic             w_mode_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;

    // State and registered outputs; reset dominates every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_limit_q <= '0;
            r_mode_q  <= 1'b0;
            r_busy    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_limit_q <= w_limit_nxt;
            r_mode_q  <= w_mode_nxt;
            r_busy    <= w_busy_nxt;
            r_wrap    <= w_wrap_nxt;
        end
    end

    // Next-state and next-output decode: stop > pause > count/terminal.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_limit_nxt = r_limit_q;
        w_mode_nxt  = r_mode_q;
        w_wrap_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_count_nxt = '0;
                if (start && !stop) begin
                    w_state_nxt = S_RUN;
                    w_limit_nxt = limit;
                    w_mode_nxt  = mode;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else if (pause) begin
                    w_state_nxt = S_HOLD;
                end else if (r_count != r_limit_q) begin
                    w_count_nxt = r_count + ONE;
                end else if (r_mode_q) begin
                    w_count_nxt = '0;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_HOLD: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else if (!pause) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_HOLD);
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign wrap  = r_wrap;
    assign done  = (r_state == S_DONE);

endmodule
